// File: rtl/branch_history_table.sv
// Direct-mapped 2-bit saturating-counter branch predictor with execute-stage
// training, mispredict detection and branch/mispredict performance counters.
module branch_history_table #(
  parameter int IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_en,
  input  logic        ex_pred_taken,
  output logic        ex_mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          table_r [ENTRIES];
  logic [31:0]         branch_count_r;
  logic [31:0]         mispredict_count_r;

  logic                upd_s;
  logic [IDX_BITS-1:0] if_idx_s;
  logic [IDX_BITS-1:0] ex_idx_s;
  logic [1:0]          ex_next_s;
  logic                unused_pc_bits_s;

  // Saturating step of a 2-bit counter toward the resolved outcome.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    case ({taken, cnt})
      3'b1_11: res = 2'b11;
      3'b1_10: res = 2'b11;
      3'b1_01: res = 2'b10;
      3'b1_00: res = 2'b01;
      3'b0_11: res = 2'b10;
      3'b0_10: res = 2'b01;
      3'b0_01: res = 2'b00;
      3'b0_00: res = 2'b00;
      default: res = 2'b01;
    endcase
    return res;
  endfunction

  assign upd_s            = ex_valid & ex_is_branch & ~ex_stall;
  assign if_idx_s         = if_pc[IDX_BITS+1:2];
  assign ex_idx_s         = ex_pc[IDX_BITS+1:2];
  assign ex_next_s        = sat_next(table_r[ex_idx_s], ex_br_en);
  assign ex_mispredict    = ex_valid & ex_is_branch & (ex_br_en != ex_pred_taken);
  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;
  assign unused_pc_bits_s = ^{if_pc[31:IDX_BITS+2], if_pc[1:0],
                              ex_pc[31:IDX_BITS+2], ex_pc[1:0]};

  // Lookup, forwarding the in-flight update when both stages hit one entry.
  always_comb begin
    if_pred_taken = 1'b0;
    if (upd_s && (if_idx_s == ex_idx_s)) begin
      if_pred_taken = ex_next_s[1];
    end else begin
      if_pred_taken = table_r[if_idx_s][1];
    end
  end

  // Counter table: reset to weak not-taken, trained on each resolved branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i] <= 2'b01;
      end
    end else if (upd_s) begin
      table_r[ex_idx_s] <= ex_next_s;
    end
  end

  // Performance counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_r     <= 32'd0;
      mispredict_count_r <= 32'd0;
    end else if (upd_s) begin
      branch_count_r <= branch_count_r + 32'd1;
      if (ex_mispredict) begin
        mispredict_count_r <= mispredict_count_r + 32'd1;
      end
    end
  end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Dynamic branch predictor and resolution checker for the pipelined RV32I core. A direct-mapped table of 2-bit saturating counters supplies a taken/not-taken prediction to fetch and is trained in execute by the branch comparator's `result`. The block also flags mispredictions for the flush logic and keeps branch and mispredict performance counters.

## Interface
- `IDX_BITS`, default 6: table index width; the table has 2^IDX_BITS entries.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_pc`  in  32  fetch-stage PC used for lookup.
- `if_pred_taken`  out  1  prediction for `if_pc`; combinational.
- `ex_valid`  in  1  execute stage holds a real instruction, not a bubble.
- `ex_is_branch`  in  1  the execute instruction is a conditional branch (opcode BRANCH).
- `ex_stall`  in  1  execute is frozen this cycle; no training, no counting.
- `ex_pc`  in  32  PC of the execute instruction.
- `ex_br_en`  in  1  actual outcome from the branch comparator's `result`.
- `ex_pred_taken`  in  1  prediction made for this instruction at fetch, carried down the pipe.
- `ex_mispredict`  out  1  execute branch outcome differs from its prediction; combinational.
- `branch_count`  out  32  retired-to-execute conditional branches; registered.
- `mispredict_count`  out  32  mispredicted branches; registered.

## Operation
- Index: `idx(pc) = pc[IDX_BITS+1:2]`. Aliasing between PCs is permitted; there are no tags.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken. The prediction is the counter's MSB.
- Training event `upd = ex_valid & ex_is_branch & ~ex_stall`.
- On `upd`, the counter at `idx(ex_pc)` is updated as follows:
  - `ex_br_en=1`: increment, saturating at 11.
  - `ex_br_en=0`: decrement, saturating at 00.
- Other entries are unchanged.
- `ex_mispredict = ex_valid & ex_is_branch & (ex_br_en != ex_pred_taken)`.
  - It is independent of `ex_stall`. Flush logic qualifies it with its own stall.
  - The table's current contents play no part.
- Lookup bypass: if `upd` is active and `idx(if_pc) == idx(ex_pc)`, `if_pred_taken` is the MSB of the post-update counter value. Otherwise it is the MSB of the stored counter.
- Performance counters:
  - `branch_count` increments on every `upd`.
  - `mispredict_count` increments on `upd & ex_mispredict`.
  - Both wrap modulo 2^32.
- Non-branch instructions, bubbles and stalled cycles leave all state unchanged.
- Width rules:
  - Counter arithmetic is 2-bit with explicit saturation; it never wraps.
  - Perf counters are 32-bit unsigned.

## Timing
- Reset, sampled on a `clk` edge with `rst=1`:
  - Every table entry becomes 01 (weak not-taken).
  - `branch_count` and `mispredict_count` become 0.
  - `if_pred_taken` is therefore 0 for every PC from the cycle after reset.
- `rst` has priority over `upd` in the same cycle. A training event coincident with reset is discarded.
- Reset mid-operation clears all history in one edge. There is no multi-cycle init and no busy signal.
- Latency:
  - Prediction and mispredict are 0-cycle combinational.
  - A table update is visible to a lookup of the same index in the same cycle (via the bypass) and thereafter from storage.
  - Perf counters reflect an event one cycle after it.
- Simultaneous lookup and update to different indices are independent.
- `ex_stall` held high for N cycles produces exactly zero updates. The one update is taken on the cycle the stall drops.
- `ex_pc` bits [1:0] and bits above IDX_BITS+1 are ignored.

## Test plan
- Reset then lookup: assert `rst` for 1 cycle, then sweep `if_pc` over 0x0–0xFC. Required: `if_pred_taken=0` everywhere, both counts 0.
- Saturation: apply 3 taken `upd` at `ex_pc=0x40`. Required: the counter walks 01→10→11→11 and `if_pred_taken` at 0x40 becomes 1 after the first update. Then apply 4 not-taken updates. Required: 11→10→01→00→00, and the prediction returns to 0 after the 2nd.
- Mispredict/counters: send a branch with `ex_pred_taken=0`, `ex_br_en=1`, then one with `ex_pred_taken=1`, `ex_br_en=1`. Required: `ex_mispredict` reads 1 then 0; afterwards `branch_count=2`, `mispredict_count=1`.
- Bypass: in the same cycle, set `if_pc=0x1040`, `ex_pc=0x40` (same index, IDX_BITS=6) and apply a taken `upd` on a counter holding 01. Required: `if_pred_taken=1` in that cycle.
- Gating: with `ex_stall=1` for 5 cycles (branch valid), then `ex_valid=0`, then `ex_is_branch=0`, drive `ex_br_en=1` throughout. Required: no table change and `branch_count` unchanged. Also apply `rst` coincident with a taken update. Required: entry 01, counts 0.
- Aliasing/wrap: train `ex_pc=0x0` to taken. Required: `if_pc=0x100` predicts taken. Force `branch_count` to 0xFFFFFFFF, then apply one `upd`. Required: `branch_count` wraps to 0.
